// File: rtl/ddr_arb_pkg.sv
// Shared definitions for the DDR port arbiter: FSM encoding, requester
// indices and a one-hot to index helper.
package ddr_arb_pkg;

  localparam int NUM_REQ   = 3;
  localparam int REQ_INSTR = 0;
  localparam int REQ_DATA  = 1;
  localparam int REQ_CTXT  = 2;

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_GRANT    = 3'd1,
    S_RD_BURST = 3'd2,
    S_WR_BURST = 3'd3,
    S_DONE     = 3'd4
  } state_t;

  // Index of the set bit of a one-hot requester vector (0 when empty).
  function automatic logic [1:0] onehot_idx(input logic [NUM_REQ-1:0] oh);
    logic [1:0] idx;
    idx = '0;
    for (int i = 0; i < NUM_REQ; i++)
      if (oh[i]) idx = 2'(i);
    return idx;
  endfunction

endpackage

// File: rtl/ddr_port_arbiter_if.sv
// Requester-side and DDR-controller-side signals of the DDR port arbiter.
// slave = arbiter, master = requesters plus DDR controller environment.
interface ddr_port_arbiter_if
  import ddr_arb_pkg::*;
#(
  parameter int DDR_ADDR_WIDTH = 28,
  parameter int DATA_WIDTH     = 16
);
  // requester side
  logic [NUM_REQ-1:0]                     req;
  logic [NUM_REQ-1:0]                     req_we;
  logic [NUM_REQ-1:0][DDR_ADDR_WIDTH-1:0] req_addr;
  logic [NUM_REQ-1:0][DATA_WIDTH-1:0]     req_wdata;
  logic [NUM_REQ-1:0]                     gnt;
  logic [NUM_REQ-1:0]                     done;
  logic [DATA_WIDTH-1:0]                  rdata;
  logic [NUM_REQ-1:0]                     rdata_valid;
  logic [NUM_REQ-1:0]                     wdata_req;
  // DDR controller side
  logic                      ddr_rd_req;
  logic                      ddr_wr_req;
  logic [DDR_ADDR_WIDTH-1:0] ddr_addr;
  logic [9:0]                ddr_burst_len;
  logic [DATA_WIDTH-1:0]     ddr_wdata;
  logic                      ddr_wr_data_req;
  logic                      ddr_rd_data_valid;
  logic [DATA_WIDTH-1:0]     ddr_rdata;
  logic                      ddr_rd_finish;
  logic                      ddr_wr_finish;
  logic                      err_extra_beat;

  modport slave (
    input  req, req_we, req_addr, req_wdata,
    input  ddr_wr_data_req, ddr_rd_data_valid, ddr_rdata, ddr_rd_finish, ddr_wr_finish,
    output gnt, done, rdata, rdata_valid, wdata_req,
    output ddr_rd_req, ddr_wr_req, ddr_addr, ddr_burst_len, ddr_wdata, err_extra_beat
  );

  modport master (
    output req, req_we, req_addr, req_wdata,
    output ddr_wr_data_req, ddr_rd_data_valid, ddr_rdata, ddr_rd_finish, ddr_wr_finish,
    input  gnt, done, rdata, rdata_valid, wdata_req,
    input  ddr_rd_req, ddr_wr_req, ddr_addr, ddr_burst_len, ddr_wdata, err_extra_beat
  );

endinterface

// File: rtl/ddr_arb_select.sv
// Combinational winner selection for the DDR port arbiter.
// Build option DDR_ARB_ROUND_ROBIN_EN: round-robin starting after the last
// winner (ptr_i); otherwise fixed priority CTXT > DATA > INSTR and ptr_i
// is ignored.
module ddr_arb_select
  import ddr_arb_pkg::*;
(
  input  logic [NUM_REQ-1:0] req_i,
  input  logic [1:0]         ptr_i,
  output logic [NUM_REQ-1:0] win_o
);

`ifdef DDR_ARB_ROUND_ROBIN_EN
  int   idx;
  logic found;

  // Walk requesters starting one past the last winner; first hit wins.
  always_comb begin
    win_o = '0;
    idx   = 0;
    found = 1'b0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      idx = (int'(ptr_i) + k) % NUM_REQ;
      if (!found && req_i[idx]) begin
        win_o[idx] = 1'b1;
        found      = 1'b1;
      end
    end
  end
`else
  logic ptr_unused;
  assign ptr_unused = ^ptr_i;

  // Fixed priority: context save/restore, then data cache, then fetch.
  always_comb begin
    win_o = '0;
    if      (req_i[REQ_CTXT])  win_o[REQ_CTXT]  = 1'b1;
    else if (req_i[REQ_DATA])  win_o[REQ_DATA]  = 1'b1;
    else if (req_i[REQ_INSTR]) win_o[REQ_INSTR] = 1'b1;
  end
`endif

endmodule

// File: rtl/ddr_port_arbiter.sv
// DDR port arbiter: three requesters share one DDR burst port.
// IDLE -> GRANT -> RD_BURST/WR_BURST -> DONE -> IDLE. Bursts end only on the
// controller's finish strobe; beats past BURST_LEN are dropped and flag a
// sticky error. Build option DDR_ARB_ROUND_ROBIN_EN selects round-robin
// arbitration (pointer = last winner); default is fixed priority.
module ddr_port_arbiter
  import ddr_arb_pkg::*;
#(
  parameter int DDR_ADDR_WIDTH = 28,
  parameter int DATA_WIDTH     = 16,
  parameter int BURST_LEN      = 16
)(
  input logic              clk,
  input logic              rst,
  ddr_port_arbiter_if.slave bus
);

  localparam logic [9:0] BL = 10'(BURST_LEN);

  state_t                    state_q;
  logic                      init_q;
  logic [NUM_REQ-1:0]        gnt_q, done_q;
  logic                      we_q, rd_req_q, wr_req_q, err_q;
  logic [DDR_ADDR_WIDTH-1:0] addr_q;
  logic [9:0]                cnt_q, cnt_d;
  logic [NUM_REQ-1:0]        win;
  logic [1:0]                win_idx, gnt_idx, ptr;
  logic                      rd_beat, wr_beat, in_window;

`ifdef DDR_ARB_ROUND_ROBIN_EN
  logic [1:0] ptr_q;
  assign ptr = ptr_q;
`else
  assign ptr = '0;
`endif

  ddr_arb_select u_select (
    .req_i (bus.req),
    .ptr_i (ptr),
    .win_o (win)
  );

  assign win_idx   = onehot_idx(win);
  assign gnt_idx   = onehot_idx(gnt_q);
  assign rd_beat   = (state_q == S_RD_BURST) && bus.ddr_rd_data_valid;
  assign wr_beat   = (state_q == S_WR_BURST) && bus.ddr_wr_data_req;
  assign in_window = (cnt_q < BL);
  assign cnt_d     = (cnt_q == 10'h3FF) ? cnt_q : cnt_q + 10'd1;

  // Arbitration FSM; all non-beat outputs are registered here.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= S_IDLE;
      init_q   <= 1'b0;
      gnt_q    <= '0;
      done_q   <= '0;
      we_q     <= 1'b0;
      rd_req_q <= 1'b0;
      wr_req_q <= 1'b0;
      addr_q   <= '0;
      cnt_q    <= '0;
      err_q    <= 1'b0;
`ifdef DDR_ARB_ROUND_ROBIN_EN
      ptr_q    <= '0;
`endif
    end else begin
      // one settling cycle after reset before the first grant
      init_q <= 1'b1;
      if ((rd_beat || wr_beat) && !in_window) err_q <= 1'b1;
      case (state_q)
        S_IDLE: begin
          if (init_q && |bus.req) begin
            state_q  <= S_GRANT;
            gnt_q    <= win;
            addr_q   <= bus.req_addr[win_idx];
            we_q     <= bus.req_we[win_idx];
            rd_req_q <= !bus.req_we[win_idx];
            wr_req_q <= bus.req_we[win_idx];
          end
        end
        S_GRANT: begin
          cnt_q   <= '0;
          state_q <= we_q ? S_WR_BURST : S_RD_BURST;
        end
        S_RD_BURST: begin
          if (rd_beat) cnt_q <= cnt_d;
          if (bus.ddr_rd_finish) begin
            state_q  <= S_DONE;
            rd_req_q <= 1'b0;
            done_q   <= gnt_q;
          end
        end
        S_WR_BURST: begin
          if (wr_beat) cnt_q <= cnt_d;
          if (bus.ddr_wr_finish) begin
            state_q  <= S_DONE;
            wr_req_q <= 1'b0;
            done_q   <= gnt_q;
          end
        end
        S_DONE: begin
          state_q <= S_IDLE;
          done_q  <= '0;
          gnt_q   <= '0;
`ifdef DDR_ARB_ROUND_ROBIN_EN
          ptr_q   <= gnt_idx;
`endif
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign bus.gnt            = gnt_q;
  assign bus.done           = done_q;
  assign bus.ddr_rd_req     = rd_req_q;
  assign bus.ddr_wr_req     = wr_req_q;
  assign bus.ddr_addr       = addr_q;
  assign bus.ddr_burst_len  = BL;
  assign bus.err_extra_beat = err_q;

  // Beat forwarding is combinational; only the winner's strobes can fire.
  assign bus.rdata_valid = (rd_beat && in_window) ? gnt_q : '0;
  assign bus.rdata       = (rd_beat && in_window) ? bus.ddr_rdata : '0;
  assign bus.wdata_req   = (wr_beat && in_window) ? gnt_q : '0;
  assign bus.ddr_wdata   = (state_q == S_WR_BURST) ? bus.req_wdata[gnt_idx] : '0;

endmodule
